// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind a UART core: first-word fall-through read, sticky overflow,
// level-threshold interrupt, and an idle-timeout interrupt compiled in with UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic [AW:0]   level,
    output logic          full,
    input  logic          flush,
    input  logic [AW:0]   cfg_thresh,
    input  logic [15:0]   cfg_timeout,
    input  logic          ovf_clr,
    output logic          thresh_irq,
    output logic          overflow,
    output logic          timeout_irq
);

    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr_reg, rptr_reg, level_reg;
    logic [AW:0] wptr_next, rptr_next;
    logic        overflow_reg;
    logic        empty, push, pop, ovf_event;

    assign empty     = (wptr_reg == rptr_reg);
    assign full      = (wptr_reg[AW] != rptr_reg[AW]) && (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
    assign rd_valid  = !empty;
    assign pop       = rd_en && rd_valid && !flush;
    assign push      = rx_valid && (!full || (rd_en && rd_valid)) && !flush;
    // A byte arriving during flush is discarded by the flush, not counted as an overflow.
    assign ovf_event = rx_valid && full && !(rd_en && rd_valid) && !flush;

    always_comb begin
        wptr_next = wptr_reg;
        rptr_next = rptr_reg;
        if (flush) begin
            wptr_next = '0;
            rptr_next = '0;
        end else begin
            if (push) wptr_next = wptr_reg + PTR_ONE;
            if (pop)  rptr_next = rptr_reg + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            level_reg <= wptr_next - rptr_next;
            if (ovf_event)
                overflow_reg <= 1'b1;
            else if (ovf_clr)
                overflow_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr_reg[AW-1:0]] <= rx_data;
    end

    assign rd_data    = mem[rptr_reg[AW-1:0]];
    assign level      = level_reg;
    assign overflow   = overflow_reg;
    assign thresh_irq = (cfg_thresh != '0) && (level_reg >= cfg_thresh);

`ifdef UART_RX_FIFO_TIMEOUT_EN
    logic [15:0] idle_cnt_reg;
    logic        timeout_reg;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            idle_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            if (push || pop || flush || empty)
                idle_cnt_reg <= '0;
            else if (idle_cnt_reg != 16'hFFFF)
                idle_cnt_reg <= idle_cnt_reg + 16'd1;

            // Draining or flushing services the timeout, so clear beats set.
            if (pop || flush)
                timeout_reg <= 1'b0;
            else if ((cfg_timeout != 16'd0) && (idle_cnt_reg == cfg_timeout) && !empty)
                timeout_reg <= 1'b1;
        end
    end

    assign timeout_irq = timeout_reg;
`else
    logic unused_cfg_timeout;
    assign unused_cfg_timeout = ^cfg_timeout;
    assign timeout_irq        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: ordering, overflow, full push+pop, threshold, flush, reset, timeout.
module tb_uart_rx_fifo;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [4:0]  level;
    logic        full;
    logic        flush;
    logic [4:0]  cfg_thresh;
    logic [15:0] cfg_timeout;
    logic        ovf_clr;
    logic        thresh_irq;
    logic        overflow;
    logic        timeout_irq;

    int tests = 0;
    int fails = 0;

    uart_rx_fifo #(.DEPTH(16)) dut (
        .clk(clk), .rst_b(rst_b), .rx_valid(rx_valid), .rx_data(rx_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .level(level),
        .full(full), .flush(flush), .cfg_thresh(cfg_thresh), .cfg_timeout(cfg_timeout),
        .ovf_clr(ovf_clr), .thresh_irq(thresh_irq), .overflow(overflow),
        .timeout_irq(timeout_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pop_byte();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_level"},    32'(level), 32'd0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_full"},     32'(full), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_thresh"},   32'(thresh_irq), 32'd0);
        check({tag, "_timeout"},  32'(timeout_irq), 32'd0);
    endtask

    initial begin
        rst_b       = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        rd_en       = 1'b0;
        flush       = 1'b0;
        cfg_thresh  = 5'd0;
        cfg_timeout = 16'd100;
        ovf_clr     = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        rst_b = 1'b1;
        tick();

        // Basic ordering and one-cycle fall-through latency.
        push_byte(8'h11);
        check("lat_rd_valid", 32'(rd_valid), 32'd1);
        check("lat_rd_data",  32'(rd_data), 32'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        check("three_level",  32'(level), 32'd3);
        check("three_head",   32'(rd_data), 32'h11);
        check("pop0", 32'(rd_data), 32'h11);
        pop_byte();
        check("pop1", 32'(rd_data), 32'h22);
        pop_byte();
        check("pop2", 32'(rd_data), 32'h33);
        pop_byte();
        check("drained_rd_valid", 32'(rd_valid), 32'd0);
        check("drained_level",    32'(level), 32'd0);

        // rd_en on an empty FIFO changes nothing.
        pop_byte();
        check("empty_pop_level", 32'(level), 32'd0);

        // Overflow: the 17th byte is dropped.
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        check("fill_full",     32'(full), 32'd1);
        check("fill_ovf",      32'(overflow), 32'd0);
        push_byte(8'h10);
        check("ovf_set",       32'(overflow), 32'd1);
        check("ovf_level",     32'(level), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovf_pop%0d", i), 32'(rd_data), 32'(i));
            pop_byte();
        end
        check("ovf_drained",   32'(rd_valid), 32'd0);
        check("ovf_flush_keeps", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared",   32'(overflow), 32'd0);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 16; i++) push_byte(8'hA0 + 8'(i));
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        rd_en    = 1'b1;
        tick();
        rx_valid = 1'b0;
        rd_en    = 1'b0;
        check("fullpp_level", 32'(level), 32'd16);
        check("fullpp_full",  32'(full), 32'd1);
        check("fullpp_ovf",   32'(overflow), 32'd0);
        check("fullpp_head",  32'(rd_data), 32'hA1);
        for (int i = 0; i < 15; i++) pop_byte();
        check("fullpp_last",  32'(rd_data), 32'h55);
        pop_byte();
        check("fullpp_empty", 32'(rd_valid), 32'd0);

        // Threshold interrupt.
        cfg_thresh = 5'd4;
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        check("thr_below", 32'(thresh_irq), 32'd0);
        push_byte(8'h04);
        check("thr_at",    32'(thresh_irq), 32'd1);
        pop_byte();
        check("thr_after_pop", 32'(thresh_irq), 32'd0);

        // Flush overrides a simultaneous push.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
        check("flush_pre_level", 32'(level), 32'd5);
        flush    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        tick();
        flush    = 1'b0;
        rx_valid = 1'b0;
        check("flush_level",    32'(level), 32'd0);
        check("flush_rd_valid", 32'(rd_valid), 32'd0);
        tick();
        check("flush_not_stored", 32'(level), 32'd0);

        // Asynchronous reset mid-stream with overflow pending.
        for (int i = 0; i < 17; i++) push_byte(8'(i));
        check("prerst_ovf", 32'(overflow), 32'd1);
        rx_valid = 1'b1;
        rx_data  = 8'hEE;
        #2;
        rst_b = 1'b0;
        #1;
        check_reset_state("midrst");
        rx_valid = 1'b0;
        tick();
        rst_b = 1'b1;
        tick();
        check("postrst_level", 32'(level), 32'd0);

        // Idle timeout.
        cfg_thresh = 5'd0;
        push_byte(8'h5A);
        for (int i = 0; i < 50; i++) tick();
        check("tmo_early", 32'(timeout_irq), 32'd0);
        for (int i = 0; i < 70; i++) tick();
`ifdef UART_RX_FIFO_TIMEOUT_EN
        check("tmo_fired", 32'(timeout_irq), 32'd1);
`else
        check("tmo_absent", 32'(timeout_irq), 32'd0);
`endif
        pop_byte();
        check("tmo_after_pop", 32'(timeout_irq), 32'd0);
        check("tmo_empty",     32'(rd_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
